mult_booth: RTL and testbench



---
 rtl/mult_div_pkg.sv | 34 +++
 rtl/mult_booth_if.sv | 22 ++
 rtl/mult_booth_recode.sv | 32 +++
 rtl/mult_booth.sv | 83 ++++++++
 tb/tb_mult_booth.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multdiv unit: datapath width, controller states
// and the radix-4 Booth digit codes.
package mult_div_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } multDivStateT;

  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } boothDigitT;

  // Maps a 3-bit multiplier window {b[i+1], b[i], b[i-1]} to its Booth digit.
  function automatic boothDigitT boothDigit(input logic [2:0] window);
    boothDigitT digit;
    case (window)
      3'b001, 3'b010: digit = PM;
      3'b011:         digit = P2M;
      3'b100:         digit = N2M;
      3'b101, 3'b110: digit = NM;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/mult_booth_if.sv
// Operand/result bundle shared by the multiplier and its driver (the multdiv
// wrapper or a testbench).
interface mult_booth_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/mult_booth_recode.sv
// Turns a Booth window into the addend for the accumulator; negative digits
// come out inverted with carryIn set so the top needs only one adder.
module mult_booth_recode
  import mult_div_pkg::*;
#(
  parameter int WIDTH = mult_div_pkg::WIDTH
) (
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+1:0] addend,
  output logic             carryIn
);

  always_comb begin
    addend  = '0;
    carryIn = 1'b0;
    case (boothDigit(window))
      PM:  addend = m;
      P2M: addend = m << 1;
      NM: begin
        addend  = ~m;
        carryIn = 1'b1;
      end
      N2M: begin
        addend  = ~(m << 1);
        carryIn = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed multiplier, radix-4 Booth, one digit per clock. Returns the
// low word of the product and flags signed overflow.
module mult_booth
  import mult_div_pkg::*;
#(
  parameter int WIDTH = mult_div_pkg::WIDTH,
  parameter int ITERS = WIDTH / 2
) (
  input  logic         clock,
  input  logic         reset_n,
  mult_booth_if.slave  bus
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int PW = 2 * WIDTH + 3;

  multDivStateT     state, nextState;
  logic [CW-1:0]    count;
  logic [WIDTH+1:0] mReg;
  logic [PW-1:0]    pReg;
  logic [WIDTH+1:0] addend;
  logic             carryIn;
  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   productHigh;
  logic             lastIter;

  mult_booth_recode #(.WIDTH(WIDTH)) recode (
    .window  (pReg[2:0]),
    .m       (mReg),
    .addend  (addend),
    .carryIn (carryIn)
  );

  assign sum         = pReg[PW-1:WIDTH+1] + addend + (WIDTH+2)'(carryIn);
  assign lastIter    = (count == CW'(ITERS - 1));
  // Bits 2W-1..W-1 of the product; they must all match the sign for no overflow.
  assign productHigh = pReg[2*WIDTH:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (bus.ctrl_MULT) begin
      nextState = RUN;
    end else begin
      case (state)
        RUN:     if (lastIter) nextState = DONE;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // A start pulse always wins, so a restart drops whatever was in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count               <= '0;
      mReg                <= '0;
      pReg                <= '0;
      bus.data_result     <= '0;
      bus.data_exception  <= 1'b0;
      bus.data_resultRDY  <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (bus.ctrl_MULT) begin
        count <= '0;
        mReg  <= {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
        pReg  <= {(WIDTH+2)'(0), bus.data_operandB, 1'b0};
      end else if (state == RUN) begin
        count <= count + 1'b1;
        pReg  <= {{2{sum[WIDTH+1]}}, sum, pReg[WIDTH:2]};
      end else if (state == DONE) begin
        bus.data_result    <= pReg[WIDTH:1];
        bus.data_exception <= !((&productHigh) || (~|productHigh));
        bus.data_resultRDY <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// Directed scoreboard bench for mult_booth: the stimulus side queues the expected
// result and completion cycle, a monitor checks each RDY pulse against it.
module tb_mult_booth;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 17;

  typedef struct {
    logic [31:0] result;
    logic        exc;
    int          cycle;
    string       name;
  } expT;

  logic clock;
  logic reset_n;
  int   cycle;
  int   testsRun;
  int   testsFailed;
  expT  sbQ[$];

  mult_booth_if #(.WIDTH(WIDTH)) bus ();

  mult_booth #(.WIDTH(WIDTH), .ITERS(WIDTH / 2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called just after a falling edge; the next rising edge is the start edge.
  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expResult, input logic expExc,
                               input bit track);
    expT e;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    if (track) begin
      e.result = expResult;
      e.exc    = expExc;
      e.cycle  = cycle + 1 + LATENCY;
      e.name   = name;
      sbQ.push_back(e);
    end
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sbQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain timeout: %0d results still pending, expected 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  always @(negedge clock) begin
    if (bus.data_resultRDY) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected RDY at cycle %0d: result 0x%08h, none expected",
                 cycle, bus.data_result);
      end else begin
        expT e;
        e = sbQ.pop_front();
        checkOutput({e.name, " result"}, bus.data_result, e.result);
        checkOutput({e.name, " exception"}, 32'(bus.data_exception), 32'(e.exc));
        checkOutput({e.name, " rdy cycle"}, 32'(cycle), 32'(e.cycle));
      end
    end
  end

  initial begin
    testsRun          = 0;
    testsFailed       = 0;
    reset_n           = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset result", bus.data_result, 32'h0);
    checkOutput("reset exception", 32'(bus.data_exception), 32'h0);
    checkOutput("reset rdy", 32'(bus.data_resultRDY), 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    applyStimulus("3*5", 32'd3, 32'd5, 32'h0000000F, 1'b0, 1'b1);
    waitDrain(40);
    repeat (3) @(negedge clock);
    checkOutput("3*5 hold result", bus.data_result, 32'h0000000F);
    checkOutput("3*5 hold exception", 32'(bus.data_exception), 32'h0);
    checkOutput("3*5 rdy low after", 32'(bus.data_resultRDY), 32'h0);

    applyStimulus("-7*6", -32'sd7, 32'd6, 32'hFFFFFFD6, 1'b0, 1'b1);
    waitDrain(40);
    applyStimulus("max*2", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 1'b1);
    waitDrain(40);
    applyStimulus("min*-1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);
    waitDrain(40);
    applyStimulus("min*1", 32'h80000000, 32'd1, 32'h80000000, 1'b0, 1'b1);
    waitDrain(40);
    applyStimulus("2^16*2^16", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b1);
    waitDrain(40);
    applyStimulus("0*min", 32'd0, 32'h80000000, 32'h00000000, 1'b0, 1'b1);
    waitDrain(40);
    applyStimulus("-1*-1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
    waitDrain(40);
    applyStimulus("max*max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b1);
    waitDrain(40);
    applyStimulus("-2^16*2^15", 32'hFFFF0000, 32'h00008000, 32'h80000000, 1'b0, 1'b1);
    waitDrain(40);
    applyStimulus("2^15*2^16", 32'h00008000, 32'h00010000, 32'h80000000, 1'b1, 1'b1);
    waitDrain(40);
    applyStimulus("0x12345678*16", 32'h12345678, 32'd16, 32'h23456780, 1'b1, 1'b1);
    waitDrain(40);

    // Restart at edge 8 of a 9*9; only the 2*3 may complete.
    applyStimulus("9*9 aborted", 32'd9, 32'd9, 32'd81, 1'b0, 1'b0);
    repeat (7) @(negedge clock);
    applyStimulus("restart 2*3", 32'd2, 32'd3, 32'd6, 1'b0, 1'b1);
    waitDrain(40);
    repeat (10) @(negedge clock);

    applyStimulus("12*-3 operands wiggled", 32'd12, -32'sd3, 32'hFFFFFFDC, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    bus.data_operandA = 32'h7FFFFFFF;
    bus.data_operandB = 32'h55555555;
    repeat (4) @(negedge clock);
    bus.data_operandA = 32'h80000000;
    bus.data_operandB = 32'h00000000;
    waitDrain(40);

    // Reset in the middle of an operation: outputs clear at once, no RDY follows.
    applyStimulus("9*9 reset", 32'd9, 32'd9, 32'd81, 1'b0, 1'b0);
    repeat (9) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid-run reset result", bus.data_result, 32'h0);
    checkOutput("mid-run reset exception", 32'(bus.data_exception), 32'h0);
    checkOutput("mid-run reset rdy", 32'(bus.data_resultRDY), 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    checkOutput("post-reset result held", bus.data_result, 32'h0);

    applyStimulus("100*-100", 32'd100, -32'sd100, 32'hFFFFD8F0, 1'b0, 1'b1);
    waitDrain(40);
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
